// File: rtl/sram_max_scanner.sv
// Sweeps an SRAM address window and reports the signed maximum and its offset.
// Define MAX16_ABS_EN to rank words by magnitude instead of signed value.
module sram_max_scanner #(
    parameter int addr_width = 11,
    parameter int data_width = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [addr_width-1:0]        base_addr,
    input  logic [addr_width:0]          length,
    output logic [addr_width-1:0]        sram_raddr,
    input  logic signed [data_width-1:0] sram_dout,
    output logic                         busy,
    output logic                         done,
    output logic signed [data_width-1:0] max_val,
    output logic [addr_width-1:0]        max_idx
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    localparam logic signed [data_width-1:0] MIN_VAL = {1'b1, {(data_width-1){1'b0}}};
    localparam logic [addr_width-1:0] ONE_A = 1;
    localparam logic [addr_width:0]   ONE_L = 1;

    state_t                        state_q, state_d;
    logic [addr_width-1:0]         raddr_q, raddr_d;
    logic [addr_width-1:0]         last_q, last_d;
    logic [addr_width-1:0]         issue_q, issue_d;
    logic [addr_width-1:0]         off_q, off_d;
    logic                          vld_q, vld_d;
    logic                          first_q, first_d;
    logic signed [data_width-1:0]  max_val_q, max_val_d;
    logic [addr_width-1:0]         max_idx_q, max_idx_d;
    logic [addr_width:0]           len_m1;
    logic                          better;

`ifdef MAX16_ABS_EN
    // One extra bit so the magnitude of the most negative word fits.
    logic [data_width:0] ext_new, ext_cur, mag_new, mag_cur;

    always_comb begin
        ext_new = {sram_dout[data_width-1], sram_dout};
        ext_cur = {max_val_q[data_width-1], max_val_q};
        mag_new = sram_dout[data_width-1] ? -ext_new : ext_new;
        mag_cur = max_val_q[data_width-1] ? -ext_cur : ext_cur;
        better  = mag_new > mag_cur;
    end
`else
    always_comb begin
        better = sram_dout > max_val_q;
    end
`endif

    always_comb begin
        state_d   = state_q;
        raddr_d   = raddr_q;
        last_d    = last_q;
        issue_d   = issue_q;
        off_d     = off_q;
        vld_d     = 1'b0;
        first_d   = first_q;
        max_val_d = max_val_q;
        max_idx_d = max_idx_q;
        len_m1    = length - ONE_L;

        // first_q stands in for the "below everything" initial value
        if (vld_q && (first_q || better)) begin
            max_val_d = sram_dout;
            max_idx_d = off_q;
            first_d   = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    max_val_d = MIN_VAL;
                    max_idx_d = '0;
                    first_d   = 1'b1;
                    issue_d   = '0;
                    last_d    = len_m1[addr_width-1:0];
                    if (length == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = READ;
                        raddr_d = base_addr;
                    end
                end
            end
            READ: begin
                vld_d = 1'b1;
                off_d = issue_q;
                if (issue_q == last_q) begin
                    state_d = DRAIN;
                end else begin
                    issue_d = issue_q + ONE_A;
                    raddr_d = raddr_q + ONE_A;
                end
            end
            DRAIN: state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            raddr_q   <= '0;
            last_q    <= '0;
            issue_q   <= '0;
            off_q     <= '0;
            vld_q     <= 1'b0;
            first_q   <= 1'b0;
            max_val_q <= MIN_VAL;
            max_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            raddr_q   <= raddr_d;
            last_q    <= last_d;
            issue_q   <= issue_d;
            off_q     <= off_d;
            vld_q     <= vld_d;
            first_q   <= first_d;
            max_val_q <= max_val_d;
            max_idx_q <= max_idx_d;
        end
    end

    assign sram_raddr = raddr_q;
    assign busy       = (state_q == READ) || (state_q == DRAIN);
    assign done       = (state_q == DONE);
    assign max_val    = max_val_q;
    assign max_idx    = max_idx_q;

endmodule

// File: tb/tb_sram_max_scanner.sv
// Bench for sram_max_scanner: table vectors, control corner cases and
// random windows checked against a simple array-based reference.
module tb_sram_max_scanner;

    localparam int AW    = 11;
    localparam int DW    = 32;
    localparam int DEPTH = 2048;
    localparam int MINI  = 32'sh8000_0000;
    localparam int MAXI  = 32'sh7fff_ffff;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [AW-1:0]        base_addr;
    logic [AW:0]          length;
    logic [AW-1:0]        sram_raddr;
    logic signed [DW-1:0] sram_dout;
    logic                 busy;
    logic                 done;
    logic signed [DW-1:0] max_val;
    logic [AW-1:0]        max_idx;

    logic signed [DW-1:0] mem [DEPTH];

    int total = 0;
    int bad   = 0;

    sram_max_scanner #(.addr_width(AW), .data_width(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .sram_raddr(sram_raddr),
        .sram_dout (sram_dout),
        .busy      (busy),
        .done      (done),
        .max_val   (max_val),
        .max_idx   (max_idx)
    );

    always #5 clk = ~clk;

    // SRAM read port: registered address, data one cycle later
    always @(posedge clk) sram_dout <= mem[sram_raddr];

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic longint rank(input logic signed [DW-1:0] v);
`ifdef MAX16_ABS_EN
        return (v < 0) ? -longint'(v) : longint'(v);
`else
        return longint'(v);
`endif
    endfunction

    task automatic ref_scan(input int base, input int len,
                            output int val, output int idx);
        logic signed [DW-1:0] w;
        val = MINI;
        idx = 0;
        for (int k = 0; k < len; k++) begin
            w = mem[(base + k) % DEPTH];
            if (k == 0 || rank(w) > rank(val)) begin
                val = w;
                idx = k;
            end
        end
    endtask

    task automatic run_scan(input int base, input int len, input bit noise,
                            input string tag, output int ev, output int ei);
        int            done_c;
        int            got;
        bit            addr_ok;
        bit            busy_ok;
        logic [AW-1:0] raddr0;
        done_c  = (len == 0) ? 1 : len + 2;
        got     = -1;
        addr_ok = 1'b1;
        busy_ok = 1'b1;
        @(negedge clk);
        raddr0    = sram_raddr;
        start     = 1'b1;
        base_addr = AW'(base);
        length    = (AW+1)'(len);
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= done_c + 4; c++) begin
            @(negedge clk);
            if (c <= len && sram_raddr !== AW'(base + c - 1)) addr_ok = 1'b0;
            if (len == 0 && sram_raddr !== raddr0) addr_ok = 1'b0;
            if (busy !== (c < done_c)) busy_ok = 1'b0;
            if (done === 1'b1) begin
                got = c;
                break;
            end
            if (noise) begin
                start     = 1'($urandom);
                base_addr = AW'($urandom);
                length    = (AW+1)'($urandom_range(0, 20));
            end
        end
        start = 1'b0;
        ref_scan(base, len, ev, ei);
        check({tag, ".done_cycle"}, got, done_c);
        check({tag, ".addr_seq"}, addr_ok, 1);
        check({tag, ".busy"}, busy_ok, 1);
        check({tag, ".max_val"}, max_val, ev);
        check({tag, ".max_idx"}, max_idx, ei);
    endtask

    typedef struct {
        int base;
        int len;
        int w[4];
        int ev;
        int ei;
    } vec_t;

    function automatic vec_t mk(int b, int l, int w0, int w1, int w2, int w3,
                                int ev, int ei);
        vec_t v;
        v.base = b;
        v.len  = l;
        v.w[0] = w0;
        v.w[1] = w1;
        v.w[2] = w2;
        v.w[3] = w3;
        v.ev   = ev;
        v.ei   = ei;
        return v;
    endfunction

    vec_t vecs[8];

    initial begin
        int ev;
        int ei;
        int b;
        int l;
        bit no_done;

        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;

        vecs[0] = mk(0,    4, 5, -3, 9, 2, 9, 2);
        vecs[1] = mk(100,  3, 7, 7, 1, 0, 7, 0);
`ifdef MAX16_ABS_EN
        vecs[2] = mk(200,  3, -10, -2, MINI, 0, MINI, 2);
        vecs[5] = mk(400,  3, 3, -9, 9, 0, -9, 1);
        vecs[6] = mk(500,  2, MINI, MAXI, 0, 0, MINI, 0);
`else
        vecs[2] = mk(200,  3, -10, -2, MINI, 0, -2, 1);
        vecs[5] = mk(400,  3, 3, -9, 9, 0, 9, 2);
        vecs[6] = mk(500,  2, MINI, MAXI, 0, 0, MAXI, 1);
`endif
        vecs[3] = mk(300,  1, MINI, 0, 0, 0, MINI, 0);
        vecs[4] = mk(2046, 4, 1, 3, 0, 50, 50, 3);
        vecs[7] = mk(600,  0, 0, 0, 0, 0, MINI, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.raddr", sram_raddr, 0);
        check("reset.max_val", max_val, MINI);
        check("reset.max_idx", max_idx, 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < vecs[i].len; k++)
                mem[(vecs[i].base + k) % DEPTH] = vecs[i].w[k];
            run_scan(vecs[i].base, vecs[i].len, 1'b0, $sformatf("vec%0d", i), ev, ei);
            check($sformatf("vec%0d.tbl_val", i), max_val, vecs[i].ev);
            check($sformatf("vec%0d.tbl_idx", i), max_idx, vecs[i].ei);
        end

        repeat (3) @(negedge clk);
        check("hold.max_val", max_val, vecs[7].ev);
        check("hold.max_idx", max_idx, vecs[7].ei);

        // Reset in the third busy cycle of an 8-word scan
        for (int k = 0; k < 8; k++) mem[700 + k] = $urandom;
        @(negedge clk);
        start     = 1'b1;
        base_addr = AW'(700);
        length    = (AW+1)'(8);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort.busy", busy, 0);
        check("abort.done", done, 0);
        check("abort.raddr", sram_raddr, 0);
        check("abort.max_val", max_val, MINI);
        check("abort.max_idx", max_idx, 0);
        rst = 1'b0;
        no_done = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) no_done = 1'b0;
        end
        check("abort.quiet", no_done, 1);
        run_scan(700, 8, 1'b0, "after_abort", ev, ei);

        // Random windows, some with start noise while busy
        for (int i = 0; i < 40; i++) begin
            b = $urandom_range(0, DEPTH - 1);
            l = (i % 8 == 7) ? 0 : $urandom_range(1, 40);
            for (int k = 0; k < l; k++) begin
                case ($urandom_range(0, 2))
                    0: mem[(b + k) % DEPTH] = $urandom_range(0, 6) - 3;
                    1: mem[(b + k) % DEPTH] = ($urandom_range(0, 1) == 0) ? MINI : MAXI;
                    default: mem[(b + k) % DEPTH] = $urandom;
                endcase
            end
            run_scan(b, l, (i % 3 == 0), $sformatf("rnd%0d", i), ev, ei);
            if (i % 4 == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        for (int k = 0; k < DEPTH; k++) mem[k] = $urandom;
        run_scan($urandom_range(0, DEPTH - 1), DEPTH, 1'b0, "full", ev, ei);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
